// File: rtl/steer_queue_pkg.sv
// steer_queue_pkg: shared definitions for the dual-issue steering queue.
//   - INST_WIDTH_DEFAULT : default instruction width
//   - OP_CODE_*          : opcodes that classify as branch-pipe work
//   - NOP_INSTRUCTION    : filler placed on unused issue slots
//   - pipe_t             : pipe class of an instruction (branch, memory, either)
package steer_queue_pkg;

    localparam int INST_WIDTH_DEFAULT = 32;

    // Compare/test opcodes live in the 00xxxx and 01xxxx groups; every
    // other opcode in those groups can go to either pipe.
    localparam logic [5:0] OP_CODE_CMP   = 6'b000101;
    localparam logic [5:0] OP_CODE_TEST  = 6'b000110;
    localparam logic [5:0] OP_CODE_CMPI  = 6'b010101;
    localparam logic [5:0] OP_CODE_TESTI = 6'b010110;

    localparam logic [INST_WIDTH_DEFAULT-1:0] NOP_INSTRUCTION = '0;

    localparam int PIPE_BITS = 2;

    typedef enum logic [PIPE_BITS-1:0] {
        PIPE_DONT_CARE = 2'd0,
        PIPE_BRANCH    = 2'd1,
        PIPE_MEMORY    = 2'd2
    } pipe_t;

endpackage

// File: rtl/steer_queue_if.sv
// steer_queue_if: fetch-side and issue-side signals of the steering queue.
//   Fetch side : fetch_inst0 (older), fetch_inst1 (younger), fetch_valid[1:0],
//                fetch_ready (queue has room for a full pair).
//   Issue side : slot0_* (branch pipe), slot1_* (memory pipe), first
//                (1 = slot1 holds the older instruction), issue_ready.
// Handshake: a fetch pair is taken on a clock edge where fetch_ready and
// fetch_valid[0] are both high (lane1 only if fetch_valid[1]); the valid
// issue slots are consumed on a clock edge where issue_ready is high.
// Slot outputs are presented whether or not issue_ready is high.
interface steer_queue_if #(
    parameter int INST_WIDTH = 32
);
    logic [INST_WIDTH-1:0] fetch_inst0;
    logic [INST_WIDTH-1:0] fetch_inst1;
    logic [1:0]            fetch_valid;
    logic                  fetch_ready;
    logic                  issue_ready;
    logic [INST_WIDTH-1:0] slot0_inst;
    logic                  slot0_valid;
    logic [INST_WIDTH-1:0] slot1_inst;
    logic                  slot1_valid;
    logic                  first;

    // Queue side.
    modport slave (
        input  fetch_inst0, fetch_inst1, fetch_valid, issue_ready,
        output fetch_ready, slot0_inst, slot0_valid, slot1_inst, slot1_valid, first
    );

    // Fetch unit / execution pipes side.
    modport master (
        output fetch_inst0, fetch_inst1, fetch_valid, issue_ready,
        input  fetch_ready, slot0_inst, slot0_valid, slot1_inst, slot1_valid, first
    );
endinterface

// File: rtl/steer_classify.sv
// steer_classify: maps a 6-bit opcode to the pipe it must issue on.
//   opcode : instruction opcode field
//   pipe   : PIPE_BRANCH, PIPE_MEMORY or PIPE_DONT_CARE
module steer_classify
    import steer_queue_pkg::*;
(
    input  logic [5:0] opcode,
    output pipe_t      pipe
);

    always_comb begin
        pipe = PIPE_DONT_CARE;
        case (opcode[5:4])
            2'b00: if (opcode == OP_CODE_CMP || opcode == OP_CODE_TEST) pipe = PIPE_BRANCH;
            2'b01: if (opcode == OP_CODE_CMPI || opcode == OP_CODE_TESTI) pipe = PIPE_BRANCH;
            2'b10: pipe = PIPE_MEMORY;
            default: pipe = PIPE_BRANCH;
        endcase
    end

endmodule

// File: rtl/steer_queue.sv
// steer_queue: in-order instruction queue that steers up to two head
// instructions per cycle onto the branch pipe (slot0) and memory pipe (slot1).
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : steer_queue_if.slave (fetch push and issue slots)
//   flush          : discard the whole queue; wins over push and pop
//   conflict_count : saturating count of cycles where a pipe conflict held
//                    the younger head instruction back
module steer_queue
    import steer_queue_pkg::*;
#(
    parameter int INST_WIDTH = INST_WIDTH_DEFAULT,
    parameter int OPCODE_MSB = 31,
    parameter int OPCODE_LSB = 26,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    steer_queue_if.slave         bus,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] conflict_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INSTRUCTION);

    logic [INST_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic [INST_WIDTH-1:0] h0, h1;
    logic                  h0_valid, h1_valid;
    pipe_t                 c0, c1;

    logic [INST_WIDTH-1:0] slot0_inst, slot1_inst;
    logic                  slot0_valid, slot1_valid, first;
    logic [1:0]            issue_n;

    logic                  fetch_ready;
    logic                  push_en, pop_en, conflict;
    logic [1:0]            push_n, pop_n;

    // Pointer arithmetic at PTR_W bits wraps modulo DEPTH for free.
    assign h0       = mem[rd_ptr];
    assign h1       = mem[rd_ptr + PTR_W'(1)];
    assign h0_valid = (count != '0);
    assign h1_valid = (count >= CNT_W'(2));

    steer_classify u_class0 (.opcode(h0[OPCODE_MSB:OPCODE_LSB]), .pipe(c0));
    steer_classify u_class1 (.opcode(h1[OPCODE_MSB:OPCODE_LSB]), .pipe(c1));

    // Issue selection. A younger instruction is held (not issued) when it
    // needs the same pipe as the older one.
    always_comb begin
        slot0_inst  = NOP;
        slot1_inst  = NOP;
        slot0_valid = 1'b0;
        slot1_valid = 1'b0;
        first       = 1'b0;
        issue_n     = 2'd0;
        if (h0_valid) begin
            case (c0)
                PIPE_BRANCH: begin
                    slot0_inst  = h0;
                    slot0_valid = 1'b1;
                    issue_n     = 2'd1;
                    if (h1_valid && c1 != PIPE_BRANCH) begin
                        slot1_inst  = h1;
                        slot1_valid = 1'b1;
                        issue_n     = 2'd2;
                    end
                end
                PIPE_MEMORY: begin
                    slot1_inst  = h0;
                    slot1_valid = 1'b1;
                    first       = 1'b1;
                    issue_n     = 2'd1;
                    if (h1_valid && c1 != PIPE_MEMORY) begin
                        slot0_inst  = h1;
                        slot0_valid = 1'b1;
                        issue_n     = 2'd2;
                    end
                end
                default: begin
                    slot0_inst  = h0;
                    slot0_valid = 1'b1;
                    issue_n     = 2'd1;
                    if (h1_valid) begin
                        issue_n     = 2'd2;
                        slot1_valid = 1'b1;
                        if (c1 == PIPE_BRANCH) begin
                            slot0_inst = h1;
                            slot1_inst = h0;
                            first      = 1'b1;
                        end else begin
                            slot1_inst = h1;
                        end
                    end
                end
            endcase
        end
    end

    // Room for a full pair, judged on registered count only (no pop credit).
    assign fetch_ready = (count <= CNT_W'(DEPTH - 2));
    assign push_en     = fetch_ready & bus.fetch_valid[0] & ~flush;
    assign push_n      = push_en ? (bus.fetch_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    assign pop_en      = bus.issue_ready & ~flush;
    assign pop_n       = pop_en ? issue_n : 2'd0;
    assign conflict    = pop_en & h1_valid & (issue_n == 2'd1);

    // Storage carries no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= bus.fetch_inst0;
            if (bus.fetch_valid[1]) mem[wr_ptr + PTR_W'(1)] <= bus.fetch_inst1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    // Flush does not clear the counter; it is a long-lived statistic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_count <= '0;
        end else if (conflict && conflict_count != '1) begin
            conflict_count <= conflict_count + CNT_WIDTH'(1);
        end
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.slot0_inst  = slot0_inst;
    assign bus.slot0_valid = slot0_valid;
    assign bus.slot1_inst  = slot1_inst;
    assign bus.slot1_valid = slot1_valid;
    assign bus.first       = first;

endmodule

// File: doc/steer_queue.md
Name: steer_queue

Overview:
- Parametrised successor to the dual-issue steering stage; sits between fetch and the two execution pipes.
- Buffers fetched instructions in an in-order queue of DEPTH single-instruction entries. Each cycle it steers up to two head instructions: slot 0 is the branch pipe, slot 1 is the memory pipe.
- A pipe conflict holds the younger instruction in the queue instead of replaying it with a stall pulse.
- Adds fetch backpressure, downstream ready, flush, and a saturating conflict counter.

Parameters:
- INST_WIDTH, 32, instruction width
- OPCODE_MSB, 31, opcode MSB within the instruction
- OPCODE_LSB, 26, opcode LSB (opcode is 6 bits)
- DEPTH, 8, queue entries; power of two, >=4
- CNT_WIDTH, 16, conflict counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_inst0  in  INST_WIDTH  older fetched instruction
- fetch_inst1  in  INST_WIDTH  younger fetched instruction
- fetch_valid  in  2  lane valids; bit1 set only if bit0 set
- fetch_ready  out  1  high when free entries >= 2
- flush  in  1  discard queue contents
- issue_ready  in  1  downstream accepts slots this cycle
- slot0_inst  out  INST_WIDTH  branch-pipe instruction, NOP_INSTRUCTION when empty
- slot0_valid  out  1  slot0 carries a real instruction
- slot1_inst  out  INST_WIDTH  memory-pipe instruction, NOP_INSTRUCTION when empty
- slot1_valid  out  1  slot1 carries a real instruction
- first  out  1  1 = slot1 holds the older instruction
- conflict_count  out  CNT_WIDTH  saturating count of conflict cycles

Behaviour:
- Classification of the opcode:
  - 000000 -> X (dont care).
  - 00xxxx -> BRANCH if OP_CODE_CMP or OP_CODE_TEST, else X.
  - 01xxxx -> BRANCH if OP_CODE_CMPI or OP_CODE_TESTI, else X.
  - 10xxxx -> MEMORY.
  - 11xxxx -> BRANCH.
- Queue: circular buffer with rd_ptr, wr_ptr and count (0..DEPTH).
  - Push when fetch_ready & fetch_valid[0]: lane0 at wr_ptr, then lane1 at wr_ptr+1 if fetch_valid[1].
  - Pointers wrap modulo DEPTH.
  - fetch_ready = (DEPTH - count >= 2), using the pre-pop count. It is registered-state only, with no same-cycle pop credit.
  - Push-to-head latency: 1 cycle, no bypass.
- Issue is combinational from the head. h0 is valid when count>=1; h1 is valid when count>=2.
  - h0 BRANCH: slot0=h0, first=0. If h1 is MEMORY or X, also slot1=h1 (issue 2); else issue 1.
  - h0 MEMORY: slot1=h0, first=1. If h1 is BRANCH or X, also slot0=h1 (issue 2); else issue 1.
  - h0 X, h1 BRANCH: slot0=h1, slot1=h0, first=1 (issue 2).
  - h0 X, h1 MEMORY or X: slot0=h0, slot1=h1, first=0 (issue 2).
  - h0 X, h1 invalid: slot0=h0, first=0 (issue 1).
  - count==0: both slots invalid/NOP, first=0.
  - Unused slots output NOP_INSTRUCTION with valid=0.
  - Slot outputs are presented regardless of issue_ready.
- Pop: when issue_ready & !flush, rd_ptr advances by the number issued and count updates by pushed - popped in the same cycle.
  - When issue_ready=0, the queue holds and outputs are stable unless a push adds h1.
- Conflict: h1 valid and only one issued, while issue_ready & !flush. conflict_count increments and saturates at all-ones.
- Flush: has priority over push and pop. Next cycle count=0, pointers=0, slots invalid. Fetch data presented in the flush cycle is dropped. conflict_count is retained.
- Reset (async assert, sync-safe release) gives:
  - count=0, pointers=0
  - slot valids=0, slot insts=NOP_INSTRUCTION, first=0
  - fetch_ready=1
  - conflict_count=0
- Reset mid-operation discards all queued entries.

Decomposition:
- Shared package: INST_WIDTH default, OP_CODE_* constants, NOP_INSTRUCTION, and PIPE_BITS/PIPE_BRANCH/PIPE_MEMORY/PIPE_DONT_CARE.
- Sub-module steer_classify (opcode -> pipe class, combinational), instantiated twice for h0 and h1.
- Queue storage, pointers, issue mux and counter stay in steer_queue.

Test Plan:
- Reset, then push {add, jmp} with fetch_valid=11 -> next cycle slot0=jmp, slot1=add, first=1; both valid; count 2->0 with issue_ready=1.
- Push {lw, sw} -> cycle 1: slot1=lw, slot0 invalid, first=1, conflict_count=1. Cycle 2: slot1=sw, first=1, conflict_count stays 1.
- Push {jmp, cmp} -> cycle 1: slot0=jmp only, conflict_count increments. Cycle 2: slot0=cmp, first=0.
- Fill DEPTH=8 with issue_ready=0 via four pushes -> fetch_ready=0 after the 4th push and count=8. A 5th push is ignored.
- Wrap: with issue_ready=1, run 20 mixed pushes past pointer wrap -> issue order matches a reference model exactly and no instruction is lost or duplicated.
- Flush with count=5 and a simultaneous push -> next cycle count=0, slots NOP/invalid, fetch_ready=1, conflict_count unchanged.
